// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader that fills instruction memory and releases the core
// Frame: 16-bit word count, N big-endian words, 8-bit checksum making the byte sum zero.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          im_wr_en,
    output logic [AW-1:0] im_wr_addr,
    output logic [31:0]   im_wr_data,
    output logic          core_rst,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0]   DEPTH_L  = 17'(DEPTH);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t        r_state;
    logic [7:0]    r_len_hi;
    logic [7:0]    r_sum;
    logic [16:0]   r_words_left;
    logic [AW-1:0] r_word_addr;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_asm;
    logic          r_in_ready;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_core_rst;
    logic          r_done;
    logic          r_err;

    logic          w_xfer;
    logic [7:0]    w_sum_next;
    logic [16:0]   w_count;

    assign w_xfer     = in_valid && r_in_ready;
    assign w_sum_next = r_sum + in_data;
    assign w_count    = {1'b0, r_len_hi, in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LEN_HI;
            r_len_hi     <= '0;
            r_sum        <= '0;
            r_words_left <= '0;
            r_word_addr  <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_in_ready   <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            // Core leaves reset one cycle after done, so the last write has landed.
            r_core_rst <= !r_done;
            if (w_xfer) begin
                r_sum <= w_sum_next;
            end
            case (r_state)
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= in_data;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        if (w_count > DEPTH_L) begin
                            r_state    <= S_ERROR;
                            r_err      <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (w_count == 17'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state      <= S_DATA;
                            r_words_left <= w_count;
                            r_word_addr  <= '0;
                            r_byte_idx   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm      <= {r_asm[15:0], in_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Fourth byte goes straight to the write port; only three need holding.
                        if (r_byte_idx == 2'd3) begin
                            r_wr_en      <= 1'b1;
                            r_wr_addr    <= r_word_addr;
                            r_wr_data    <= {r_asm, in_data};
                            r_word_addr  <= r_word_addr + ADDR_ONE;
                            r_words_left <= r_words_left - 17'd1;
                            if (r_words_left == 17'd1) begin
                                r_state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (w_sum_next == 8'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign im_wr_en   = r_wr_en;
    assign im_wr_addr = r_wr_addr;
    assign im_wr_data = r_wr_data;
    assign core_rst   = r_core_rst;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with directed and random images
// Expected writes come from the image bytes; a negedge monitor pops and compares them.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_wr_en;
    logic [AW-1:0] im_wr_addr;
    logic [31:0]   im_wr_data;
    logic          core_rst;
    logic          done;
    logic          err;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_wr_en   (im_wr_en),
        .im_wr_addr (im_wr_addr),
        .im_wr_data (im_wr_data),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    wr_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, at its expected cycle.
    always @(negedge clk) begin
        if (im_wr_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, no write expected (cycle %0d)",
                         im_wr_addr, im_wr_data, cyc);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(im_wr_addr), 32'(w.addr));
                chk("wr_data", im_wr_data, w.data);
                chk("wr_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wr_en", 32'(im_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(im_wr_addr), 32'd0);
        chk("rst_wr_data", im_wr_data, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals();
    endtask

    task automatic make_image(input int n, input bit good, output logic [7:0] img[$]);
        logic [7:0] s;
        img = {};
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
        s = 8'd0;
        foreach (img[i]) s = s + img[i];
        img.push_back(good ? 8'(-s) : 8'(-s) ^ 8'h01);
    endtask

    task automatic send_image(input logic [7:0] img[$], input int max_stall, input bit fixed);
        int         count;
        bit         ovf;
        logic [7:0] s;
        bit         exp_done;
        int         last;
        count = {img[0], img[1]};
        ovf   = count > DEPTH;
        s     = 8'd0;
        foreach (img[i]) s = s + img[i];
        exp_done = !ovf && (s == 8'd0);
        last     = ovf ? 1 : img.size() - 1;
        for (int p = 0; p <= last; p++) begin
            int ns;
            ns = fixed ? max_stall : int'($urandom_range(max_stall, 0));
            if (p > 0) begin
                repeat (ns) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = img[p];
            chk("in_ready_loading", 32'(in_ready), 32'd1);
            if (!ovf && p >= 2 && p < 2 + 4 * count && (p - 2) % 4 == 3) begin
                wr_t w;
                w.addr = AW'((p - 2) / 4);
                w.data = {img[p-3], img[p-2], img[p-1], img[p]};
                w.cyc  = cyc + 1;
                exp_q.push_back(w);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_after_last", 32'(done), 32'(exp_done));
        chk("err_after_last", 32'(err), 32'(!exp_done));
        chk("core_rst_same_cycle", 32'(core_rst), 32'd1);
        chk("in_ready_terminal", 32'(in_ready), 32'd0);
        // Extra byte offered in a terminal state must be refused.
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        chk("core_rst_next", 32'(core_rst), 32'(!exp_done));
        repeat (2) begin
            @(negedge clk);
            chk("in_ready_held", 32'(in_ready), 32'd0);
            chk("done_sticky", 32'(done), 32'(exp_done));
            chk("err_sticky", 32'(err), 32'(!exp_done));
        end
        in_valid = 1'b0;
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img[$];
        logic [7:0] two_word[$];
        two_word = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'hD1};
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_vals();

        send_image(two_word, 0, 1'b0);
        do_reset();
        send_image(two_word, 3, 1'b1);
        do_reset();

        img     = two_word;
        img[10] = 8'hD2;
        send_image(img, 0, 1'b0);
        do_reset();

        img = '{8'h04, 8'h01};
        send_image(img, 0, 1'b0);
        do_reset();

        img = '{8'h00, 8'h00, 8'h00};
        send_image(img, 0, 1'b0);
        do_reset();
        img = '{8'h00, 8'h00, 8'h01};
        send_image(img, 0, 1'b0);
        do_reset();

        // Reset coincides with the 6th byte, which would have completed word 0.
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = two_word[p];
        end
        @(negedge clk);
        in_data = two_word[5];
        rst     = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_vals();
        send_image(two_word, 0, 1'b0);
        do_reset();

        make_image(DEPTH, 1'b1, img);
        send_image(img, 0, 1'b0);
        do_reset();

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(9, 0) == 0) begin
                int c;
                c   = int'($urandom_range(65535, DEPTH + 1));
                img = '{8'(c >> 8), 8'(c)};
            end else begin
                make_image(int'($urandom_range(6, 0)), $urandom_range(3, 0) != 0, img);
            end
            send_image(img, 3, 1'b0);
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
